// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: shared state encoding and default widths for the AXI-Lite master
package axi_lite_pkg;
   localparam int AXI_ADDR_WIDTH     = 32;
   localparam int AXI_DATA_WIDTH     = 32;
   localparam int AXI_TIMEOUT_CYCLES = 255;
   typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP} axi_m_state_t;
endpackage

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding command-to-AXI-Lite bridge with response timeout
module axi_lite_master
   import axi_lite_pkg::*;
#(
   parameter int ADDR_WIDTH     = AXI_ADDR_WIDTH,
   parameter int DATA_WIDTH     = AXI_DATA_WIDTH,
   parameter int TIMEOUT_CYCLES = AXI_TIMEOUT_CYCLES
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  awvalid,
   output logic [ADDR_WIDTH-1:0] awaddr,
   output logic                  wvalid,
   output logic [DATA_WIDTH-1:0] wdata,
   input  logic                  bvalid,
   output logic                  bready,
   output logic                  arvalid,
   output logic [ADDR_WIDTH-1:0] araddr,
   input  logic                  arready,
   input  logic                  rvalid,
   input  logic [DATA_WIDTH-1:0] rdata
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   axi_m_state_t          r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic [CW-1:0]         r_cnt;
   logic                  r_cmd_ready;
   logic                  r_awvalid;
   logic                  r_arvalid;
   logic                  r_bready;
   logic                  r_rsp_valid;
   logic                  r_rsp_err;
   logic                  w_tmo;
   // compare in 32 bits so the count never wraps when TIMEOUT_CYCLES fills the counter width
   assign w_tmo     = 32'(r_cnt) + 32'd1 >= 32'(TIMEOUT_CYCLES);
   assign cmd_ready = r_cmd_ready;
   assign awvalid   = r_awvalid;
   assign wvalid    = r_awvalid;
   assign awaddr    = r_addr;
   assign wdata     = r_wdata;
   assign araddr    = r_addr;
   assign arvalid   = r_arvalid;
   assign bready    = r_bready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rsp_rdata;
   assign rsp_err   = r_rsp_err;
   // transaction FSM; every AXI and response output is a register updated here
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_rsp_rdata <= '0;
         r_cnt       <= '0;
         r_cmd_ready <= 1'b1;
         r_awvalid   <= 1'b0;
         r_arvalid   <= 1'b0;
         r_bready    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (cmd_valid && r_cmd_ready) begin
               r_addr      <= cmd_addr;
               r_wdata     <= cmd_wdata;
               r_cmd_ready <= 1'b0;
               r_cnt       <= '0;
               r_awvalid   <= cmd_write;
               r_arvalid   <= !cmd_write;
               r_state     <= cmd_write ? WR_REQ : RD_REQ;
            end
            WR_REQ: begin
               r_awvalid <= 1'b0;
               r_bready  <= 1'b1;
               r_cnt     <= '0;
               r_state   <= WR_RESP;
            end
            WR_RESP: if (bvalid || w_tmo) begin
               r_bready    <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= !bvalid;
               r_rsp_rdata <= '0;
               r_state     <= RSP;
            end else r_cnt <= r_cnt + CW'(1);
            RD_REQ: if (arready) begin
               r_arvalid <= 1'b0;
               r_cnt     <= w_tmo ? r_cnt : r_cnt + CW'(1);
               r_state   <= RD_DATA;
            end else if (w_tmo) begin
               r_arvalid   <= 1'b0;
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= 1'b1;
               r_rsp_rdata <= '0;
               r_state     <= RSP;
            end else r_cnt <= r_cnt + CW'(1);
            RD_DATA: if (rvalid || w_tmo) begin
               r_rsp_valid <= 1'b1;
               r_rsp_err   <= !rvalid;
               r_rsp_rdata <= rvalid ? rdata : '0;
               r_state     <= RSP;
            end else r_cnt <= r_cnt + CW'(1);
            RSP: if (rsp_ready) begin
               r_rsp_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: scoreboard bench for the AXI-Lite master
module tb_axi_lite_master;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 8;
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cmd_valid, cmd_ready, cmd_write;
   logic [AW-1:0] cmd_addr, awaddr, araddr;
   logic [DW-1:0] cmd_wdata, rsp_rdata, wdata, rdata;
   logic          rsp_valid, rsp_ready, rsp_err;
   logic          awvalid, wvalid, bvalid, bready, arvalid, arready, rvalid;
   int            checks = 0;
   int            errors = 0;
   logic [DW:0]   sb[$];
   logic [DW-1:0] mem[logic [AW-1:0]];

   axi_lite_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .awvalid(awvalid), .awaddr(awaddr), .wvalid(wvalid), .wdata(wdata),
      .bvalid(bvalid), .bready(bready),
      .arvalid(arvalid), .araddr(araddr), .arready(arready),
      .rvalid(rvalid), .rdata(rdata)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_ctl"}, {cmd_ready, awvalid, wvalid, arvalid, bready, rsp_valid, rsp_err}, 7'b1000000);
      chk({tag, "_addr"}, {awaddr, araddr}, 64'h0);
      chk({tag, "_data"}, {wdata, rsp_rdata}, 64'h0);
   endtask

   task automatic send_cmd(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int n = 0;
      cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
      while (!cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("cmd_accept", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // bdelay < 0: target never answers
   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input int bdelay);
      send_cmd(1'b1, a, d);
      chk("aw_w_valid", {awvalid, wvalid}, 2'b11);
      chk("awaddr", awaddr, a);
      chk("wdata", wdata, d);
      @(negedge clk);
      chk("aw_one_cycle", {awvalid, wvalid, bready}, 3'b001);
      if (bdelay < 0) begin
         sb.push_back({1'b1, {DW{1'b0}}});
         for (int i = 0; i < TO; i++) begin
            chk("wr_tmo_wait", {rsp_valid, bready}, 2'b01);
            @(negedge clk);
         end
      end else begin
         mem[a] = d;
         sb.push_back({1'b0, {DW{1'b0}}});
         repeat (bdelay) @(negedge clk);
         bvalid = 1'b1;
         @(negedge clk);
         bvalid = 1'b0;
      end
      chk("wr_rsp_valid", {rsp_valid, bready}, 2'b10);
   endtask

   task automatic rd(input logic [AW-1:0] a, input int ar_delay, input logic tmo);
      logic [DW-1:0] v;
      v = mem.exists(a) ? mem[a] : '0;
      send_cmd(1'b0, a, '0);
      if (tmo) begin
         sb.push_back({1'b1, {DW{1'b0}}});
         for (int i = 0; i < TO; i++) begin
            chk("ar_hold_tmo", {arvalid, rsp_valid}, 2'b10);
            @(negedge clk);
         end
         chk("ar_drop_tmo", {arvalid, rsp_valid}, 2'b01);
      end else begin
         sb.push_back({1'b0, v});
         for (int i = 0; i <= ar_delay; i++) begin
            chk("arvalid", arvalid, 1);
            chk("araddr", araddr, a);
            arready = (i == ar_delay);
            @(negedge clk);
         end
         arready = 1'b0;
         chk("ar_drop", arvalid, 0);
         rvalid = 1'b1; rdata = v;
         @(negedge clk);
         rvalid = 1'b0; rdata = $urandom;
         chk("rd_rsp_valid", rsp_valid, 1);
      end
   endtask

   // hold > 0: stall rsp_ready and offer a competing command meanwhile
   task automatic get_rsp(input int hold);
      logic [DW:0] e, snap;
      int n = 0;
      while (!rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("rsp_seen", rsp_valid, 1);
      snap = {rsp_err, rsp_rdata};
      for (int i = 0; i < hold; i++) begin
         cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h44; cmd_wdata = '1;
         @(negedge clk);
         chk("rsp_hold", {rsp_valid, cmd_ready, awvalid, arvalid}, 4'b1000);
         chk("rsp_stable", {rsp_err, rsp_rdata}, snap);
      end
      rsp_ready = 1'b1;
      chk("rsp_no_cmd", cmd_ready, 0);
      if (sb.size() == 0) begin
         chk("sb_underflow", sb.size(), 1);
         e = '0;
      end else e = sb.pop_front();
      chk("rsp_data", {rsp_err, rsp_rdata}, e);
      @(negedge clk);
      rsp_ready = 1'b0; cmd_valid = 1'b0;
      chk("rsp_done", {rsp_valid, cmd_ready, awvalid, arvalid}, 4'b0100);
   endtask

   initial begin
      cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0;
      rsp_ready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = '0;
      repeat (3) @(negedge clk);
      chk_reset("reset");
      rst = 1'b0;
      @(negedge clk);
      wr(32'h30, 32'hDEADBEEF, 0);
      get_rsp(0);
      rd(32'h30, 0, 1'b0);
      get_rsp(0);
      wr(32'h34, 32'h12345678, 2);
      get_rsp(0);
      rd(32'h34, 5, 1'b0);
      get_rsp(4);
      wr(32'h38, 32'hCAFEF00D, -1);
      get_rsp(0);
      rd(32'h40, 0, 1'b1);
      get_rsp(0);
      wr(32'h3C, 32'hA5A55A5A, 7);
      get_rsp(0);
      rd(32'h3C, 6, 1'b0);
      get_rsp(0);
      send_cmd(1'b0, 32'h30, '0);
      arready = 1'b1;
      @(negedge clk);
      arready = 1'b0;
      chk("rd_data_state", {arvalid, rsp_valid}, 2'b00);
      rst = 1'b1;
      #1;
      chk_reset("mid_reset");
      @(negedge clk);
      rst = 1'b0;
      rvalid = 1'b1; rdata = 32'hBAD0BAD0;
      @(negedge clk);
      rvalid = 1'b0;
      repeat (2) begin
         chk("post_reset", {rsp_valid, cmd_ready, arvalid, bready}, 4'b0100);
         @(negedge clk);
      end
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
